ifid_idex_pipe: RTL and testbench

- Holds the IF/ID and ID/EX instruction/PC pipeline slots of the 5-stage RV32I core.
- Consumes `load_use_stall` from the load-use hazard detector.
- Produces the `id_ins` (ins0) and `ex_ins` (ins1) words that the detector compares.
- Applies hold, bubble-insert and branch-flush rules, and back-pressures fetch through `if_ready`.

---
 rtl/riscv_pipe_pkg.sv | 19 +
 rtl/pipe_slot.sv | 41 ++++
 rtl/ifid_idex_pipe.sv | 96 +++++++++
 tb/tb_ifid_idex_pipe.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared RV32I pipeline constants, opcodes and the IF/ID-ID/EX hazard FSM encoding.
package riscv_pipe_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One {ins, pc, valid} pipeline register; bubble beats hold, hold beats load.
module pipe_slot
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            bubble,
  input  logic            load,
  input  logic [31:0]     nxt_ins,
  input  logic [XLEN-1:0] nxt_pc,
  input  logic            nxt_valid,
  output logic [31:0]     ins,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  // A bubble keeps the old PC; only ins/valid are scrubbed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ins   <= NOP_WORD;
      pc    <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      ins   <= NOP_WORD;
      valid <= 1'b0;
    end else if (hold) begin
      ins   <= ins;
      pc    <= pc;
      valid <= valid;
    end else if (load) begin
      ins   <= nxt_ins;
      pc    <= nxt_pc;
      valid <= nxt_valid;
    end
  end

endmodule

// File: rtl/ifid_idex_pipe.sv
// IF/ID and ID/EX slots with load-use bubble insertion, branch flush and fetch back-pressure.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module ifid_idex_pipe
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     if_ins,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic            load_use_stall,
  input  logic            flush,
  output logic [31:0]     id_ins,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid,
  output logic [31:0]     ex_ins,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_valid,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  pipe_state_e state, state_nxt;
  logic        stall_eff;
  logic        id_bubble;
  logic        ex_bubble;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // The BUBBLE state masks the detector so one load-use pair costs one cycle.
  always_comb begin
    stall_eff = load_use_stall & id_valid & ex_valid & (state == RUN) & ~flush;
    if_ready  = ~stall_eff & rst_n;
    id_bubble = flush | (~stall_eff & ~if_valid);
    ex_bubble = flush | stall_eff;
    state_nxt = RUN;
    if (stall_eff) state_nxt = BUBBLE;
  end

  pipe_slot #(.XLEN(XLEN), .NOP_WORD(NOP_WORD)) u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (stall_eff),
    .bubble    (id_bubble),
    .load      (1'b1),
    .nxt_ins   (if_ins),
    .nxt_pc    (if_pc),
    .nxt_valid (1'b1),
    .ins       (id_ins),
    .pc        (id_pc),
    .valid     (id_valid)
  );

  pipe_slot #(.XLEN(XLEN), .NOP_WORD(NOP_WORD)) u_idex (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (1'b0),
    .bubble    (ex_bubble),
    .load      (1'b1),
    .nxt_ins   (id_ins),
    .nxt_pc    (id_pc),
    .nxt_valid (id_valid),
    .ins       (ex_ins),
    .pc        (ex_pc),
    .valid     (ex_valid)
  );

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_eff) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush)     flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_idex_pipe.sv
// Table vectors, hand sequences and randomized traffic against a cycle-level reference model.
module tb_ifid_idex_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LW  = 32'h0000_A283;
  localparam logic [31:0] ADD = 32'h0022_8333;
  localparam logic [31:0] ADI = 32'h0043_0393;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, if_ready, load_use_stall, flush;
  logic [31:0] if_ins, if_pc;
  logic [31:0] id_ins, id_pc, ex_ins, ex_pc, stall_cnt, flush_cnt;
  logic        id_valid, ex_valid;

  always #5 clk = ~clk;

  ifid_idex_pipe #(.XLEN(32), .NOP_WORD(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .if_ins(if_ins), .if_pc(if_pc), .if_valid(if_valid),
    .if_ready(if_ready), .load_use_stall(load_use_stall), .flush(flush),
    .id_ins(id_ins), .id_pc(id_pc), .id_valid(id_valid),
    .ex_ins(ex_ins), .ex_pc(ex_pc), .ex_valid(ex_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: two slots plus a "stalled last cycle" flag.
  logic [31:0] m_id_ins, m_id_pc, m_ex_ins, m_ex_pc, m_sc, m_fc;
  logic        m_id_v, m_ex_v, m_just_stalled;
  logic        last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_stall();
    return rst_n && load_use_stall && m_id_v && m_ex_v && !m_just_stalled && !flush;
  endfunction

  task automatic model_edge();
    logic st;
    st = model_stall();
    if (!rst_n) begin
      m_id_ins = NOP; m_id_pc = 0; m_id_v = 0;
      m_ex_ins = NOP; m_ex_pc = 0; m_ex_v = 0;
      m_just_stalled = 0; m_sc = 0; m_fc = 0;
    end else if (flush) begin
      m_id_ins = NOP; m_id_v = 0;
      m_ex_ins = NOP; m_ex_v = 0;
      m_just_stalled = 0; m_fc = m_fc + 1;
    end else if (st) begin
      m_ex_ins = NOP; m_ex_v = 0;
      m_just_stalled = 1; m_sc = m_sc + 1;
    end else begin
      m_ex_ins = m_id_ins; m_ex_pc = m_id_pc; m_ex_v = m_id_v;
      if (if_valid) begin
        m_id_ins = if_ins; m_id_pc = if_pc; m_id_v = 1;
      end else begin
        m_id_ins = NOP; m_id_v = 0;
      end
      m_just_stalled = 0;
    end
  endtask

  task automatic step();
    #1;
    last_ready = if_ready;
    chk("if_ready", {31'd0, if_ready}, {31'd0, !model_stall() && rst_n});
    @(posedge clk);
    model_edge();
    #1;
    chk("id_ins", id_ins, m_id_ins);
    chk("id_pc", id_pc, m_id_pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_id_v});
    chk("ex_ins", ex_ins, m_ex_ins);
    chk("ex_pc", ex_pc, m_ex_pc);
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex_v});
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
`else
    chk("stall_cnt_off", stall_cnt, 32'd0);
    chk("flush_cnt_off", flush_cnt, 32'd0);
`endif
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic lus, input logic fl);
    rst_n = r; if_valid = v; if_ins = ins; if_pc = pc; load_use_stall = lus; flush = fl;
  endtask

  typedef struct {
    logic        rst_n, if_valid, lus, flush;
    logic [31:0] ins, pc;
    logic        exp_ready;
    logic [31:0] exp_id_ins;
    logic        exp_id_v;
    logic [31:0] exp_ex_ins;
    logic        exp_ex_v;
  } vec_t;

  vec_t vecs[11];

  initial begin
    m_id_ins = NOP; m_id_pc = 0; m_id_v = 0; m_ex_ins = NOP; m_ex_pc = 0; m_ex_v = 0;
    m_just_stalled = 0; m_sc = 0; m_fc = 0; last_ready = 0;

    //         rst v  lus fl ins  pc      rdy id_ins id_v ex_ins ex_v
    vecs[0]  = '{0, 1, 0, 0, LW,  32'h100, 0, NOP, 0, NOP, 0};
    vecs[1]  = '{0, 1, 0, 0, LW,  32'h100, 0, NOP, 0, NOP, 0};
    vecs[2]  = '{1, 1, 0, 0, LW,  32'h100, 1, LW,  1, NOP, 0};
    vecs[3]  = '{1, 1, 0, 0, ADD, 32'h104, 1, ADD, 1, LW,  1};
    vecs[4]  = '{1, 1, 1, 0, ADI, 32'h108, 0, ADD, 1, NOP, 0};
    vecs[5]  = '{1, 1, 1, 0, ADI, 32'h108, 1, ADI, 1, ADD, 1};
    vecs[6]  = '{1, 0, 0, 0, LW,  32'h10C, 1, NOP, 0, ADI, 1};
    vecs[7]  = '{1, 0, 1, 0, LW,  32'h10C, 1, NOP, 0, NOP, 0};
    vecs[8]  = '{1, 1, 0, 0, LW,  32'h200, 1, LW,  1, NOP, 0};
    vecs[9]  = '{1, 1, 0, 0, ADD, 32'h204, 1, ADD, 1, LW,  1};
    vecs[10] = '{1, 1, 1, 1, ADI, 32'h208, 1, NOP, 0, NOP, 0};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst_n, vecs[i].if_valid, vecs[i].ins, vecs[i].pc, vecs[i].lus, vecs[i].flush);
      step();
      chk($sformatf("vec%0d_ready", i), {31'd0, last_ready}, {31'd0, vecs[i].exp_ready});
      chk($sformatf("vec%0d_id_ins", i), id_ins, vecs[i].exp_id_ins);
      chk($sformatf("vec%0d_id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].exp_id_v});
      chk($sformatf("vec%0d_ex_ins", i), ex_ins, vecs[i].exp_ex_ins);
      chk($sformatf("vec%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].exp_ex_v});
      if (i == 5) chk("held_consumer_ex_pc", ex_pc, 32'h104);
    end
`ifdef PIPE_PERF_CNT_EN
    chk("tbl_stall_cnt", stall_cnt, 32'd1);
    chk("tbl_flush_cnt", flush_cnt, 32'd1);
`else
    chk("tbl_stall_cnt", stall_cnt, 32'd0);
    chk("tbl_flush_cnt", flush_cnt, 32'd0);
`endif

    // Reset landing on the stall cycle, then LW reaches EX two edges after release.
    drive(1, 1, LW,  32'h300, 0, 0); step();
    drive(1, 1, ADD, 32'h304, 0, 0); step();
    drive(0, 1, ADI, 32'h308, 1, 0); step();
    chk("rst_mid_stall_ready", {31'd0, last_ready}, 32'd0);
    chk("rst_mid_stall_id", {id_ins[31:1], id_valid}, {NOP[31:1], 1'b0});
    chk("rst_mid_stall_ex", {ex_ins[31:1], ex_valid}, {NOP[31:1], 1'b0});
    drive(1, 1, LW, 32'h400, 0, 0); step();
    chk("post_rst_id_lw", id_ins, LW);
    drive(1, 0, 32'h0, 32'h404, 0, 0); step();
    chk("post_rst_ex_lw", ex_ins, LW);
    chk("post_rst_ex_pc", ex_pc, 32'h400);

`ifdef PIPE_PERF_CNT_EN
    // Counter wrap from all-ones.
    drive(1, 1, LW, 32'h500, 0, 0); step();
    drive(1, 1, ADD, 32'h504, 0, 0);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_sc = 32'hFFFF_FFFF;
    step();
    drive(1, 1, ADI, 32'h508, 1, 0); step();
    chk("stall_cnt_wrap", stall_cnt, 32'd0);
`endif

    // Randomized traffic, including back-to-back dependent loads.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0), $urandom,
            {$urandom_range(0, 1023), 2'b00}, $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
